// File: rtl/chaotic_iter_ctrl.sv
// chaotic_iter_ctrl: seeds and iterates the 3-D chaotic equation block, discards the transient and streams samples; optional WAIT watchdog under CHAOS_ITER_TIMEOUT_EN
module chaotic_iter_ctrl #(
  parameter int DATA_WIDTH     = 64,
  parameter int CNT_WIDTH      = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_start,
  input  logic                  i_stop,
  input  logic [DATA_WIDTH-1:0] i_x0,
  input  logic [DATA_WIDTH-1:0] i_y0,
  input  logic [DATA_WIDTH-1:0] i_z0,
  input  logic [CNT_WIDTH-1:0]  i_discard,
  input  logic [CNT_WIDTH-1:0]  i_num_samples,
  input  logic                  i_eq_busy,
  output logic                  o_n_valid,
  output logic [DATA_WIDTH-1:0] o_xn,
  output logic [DATA_WIDTH-1:0] o_yn,
  output logic [DATA_WIDTH-1:0] o_zn,
  input  logic                  i_n1_valid,
  input  logic [DATA_WIDTH-1:0] i_xn1,
  input  logic [DATA_WIDTH-1:0] i_yn1,
  input  logic [DATA_WIDTH-1:0] i_zn1,
  output logic                  o_out_valid,
  input  logic                  i_out_ready,
  output logic [DATA_WIDTH-1:0] o_out_x,
  output logic [DATA_WIDTH-1:0] o_out_y,
  output logic [DATA_WIDTH-1:0] o_out_z,
  output logic                  o_running,
  output logic                  o_done,
  output logic                  o_timeout_err
);
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_OUT} state_t;
  state_t r_state, w_next;
  logic                 r_stop_pend;
  logic [CNT_WIDTH-1:0] r_discard, r_num, r_iter_cnt, r_sample_cnt;
  logic [CNT_WIDTH:0]   w_sample_inc;
  logic                 w_in_transient, w_last, w_timeout;
  assign w_in_transient = r_iter_cnt < r_discard;
  assign w_sample_inc   = {1'b0, r_sample_cnt} + 1'b1;
  assign w_last         = r_stop_pend || (r_num != '0 && w_sample_inc == {1'b0, r_num});
  assign o_running      = r_state != S_IDLE;
`ifdef CHAOS_ITER_TIMEOUT_EN
  localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT_CYCLES - 1);
  logic [WDW-1:0] r_wd_cnt;
  assign w_timeout = r_state == S_WAIT && !i_n1_valid && r_wd_cnt == WD_LAST;
  // Watchdog: counts cycles spent in WAIT; error is sticky until the next accepted start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wd_cnt      <= '0;
      o_timeout_err <= 1'b0;
    end else begin
      r_wd_cnt      <= r_state == S_WAIT ? r_wd_cnt + 1'b1 : '0;
      o_timeout_err <= w_timeout ? 1'b1 : (r_state == S_IDLE && i_start) ? 1'b0 : o_timeout_err;
    end
  end
`else
  assign w_timeout     = 1'b0;
  assign o_timeout_err = 1'b0;
`endif
  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end
  // Next-state: stop_pend is only consulted at the ISSUE and OUT decision points
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  w_next = i_start ? S_ISSUE : S_IDLE;
      S_ISSUE: w_next = r_stop_pend ? S_IDLE : i_eq_busy ? S_ISSUE : S_WAIT;
      S_WAIT:  w_next = w_timeout ? S_IDLE : !i_n1_valid ? S_WAIT : w_in_transient ? S_ISSUE : S_OUT;
      S_OUT:   w_next = !i_out_ready ? S_OUT : w_last ? S_IDLE : S_ISSUE;
      default: w_next = S_IDLE;
    endcase
  end
  // Datapath: seeding, result capture/feedback, saturating counters, strobes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_n_valid    <= 1'b0;
      o_done       <= 1'b0;
      o_out_valid  <= 1'b0;
      r_stop_pend  <= 1'b0;
      r_discard    <= '0;
      r_num        <= '0;
      r_iter_cnt   <= '0;
      r_sample_cnt <= '0;
      o_xn         <= '0;
      o_yn         <= '0;
      o_zn         <= '0;
      o_out_x      <= '0;
      o_out_y      <= '0;
      o_out_z      <= '0;
    end else begin
      o_n_valid   <= r_state == S_ISSUE && !r_stop_pend && !i_eq_busy;
      o_done      <= r_state != S_IDLE && w_next == S_IDLE;
      r_stop_pend <= w_next != S_IDLE && (r_stop_pend || i_stop);
      if (r_state == S_IDLE && i_start) begin
        o_xn         <= i_x0;
        o_yn         <= i_y0;
        o_zn         <= i_z0;
        r_discard    <= i_discard;
        r_num        <= i_num_samples;
        r_iter_cnt   <= '0;
        r_sample_cnt <= '0;
      end
      if (r_state == S_WAIT && i_n1_valid) begin
        o_xn        <= i_xn1;
        o_yn        <= i_yn1;
        o_zn        <= i_zn1;
        o_out_x     <= i_xn1;
        o_out_y     <= i_yn1;
        o_out_z     <= i_zn1;
        r_iter_cnt  <= &r_iter_cnt ? r_iter_cnt : r_iter_cnt + 1'b1;
        o_out_valid <= !w_in_transient;
      end
      if (r_state == S_OUT && i_out_ready) begin
        o_out_valid  <= 1'b0;
        r_sample_cnt <= &r_sample_cnt ? r_sample_cnt : r_sample_cnt + 1'b1;
      end
    end
  end
endmodule
